// File: rtl/nanocalc_result_display.sv
// nanocalc_result_display
//
// Result-bus consumer for the nanocalc core. Captures an 8-bit result on a
// valid strobe. Converts it to three BCD digits with a sequential
// double-dabble engine. Drives a time-multiplexed 4-position 7-segment
// display: sign, hundreds, tens and ones.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   ena          design enable; freezes the scan and blanks the outputs when low
//   result_in    8-bit result from the calculator core
//   result_valid single-cycle strobe qualifying result_in
//   signed_mode  1 = treat result_in as two's complement (sampled with the strobe)
//   busy         high while a conversion is in progress
//   conv_done    one-cycle pulse when new digits reach the display registers
//   seg          segments {g,f,e,d,c,b,a}
//   dp           decimal point, always inactive
//   digit_en     one-hot position select: bit0 ones .. bit3 sign

module nanocalc_result_display #(
    parameter int unsigned REFRESH_DIV    = 1024,
    parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] result_in,
    input  logic       result_valid,
    input  logic       signed_mode,
    output logic       busy,
    output logic       conv_done,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] digit_en
);

    localparam int unsigned     CntW   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    localparam logic [6:0] SegBlank = 7'h00;
    localparam logic [6:0] SegMinus = 7'h40;
    localparam logic [6:0] SegInv   = {7{SEG_ACTIVE_LOW}};
    localparam logic [3:0] EnInv    = {4{SEG_ACTIVE_LOW}};

    typedef enum logic [1:0] {
        StIdle,
        StConv,
        StLoad
    } state_e;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // Active-high 7-segment code for one decimal digit.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = SegBlank;
        endcase
        return s;
    endfunction

    // One double-dabble iteration on the {bcd[11:0], bin[7:0]} register.
    function automatic logic [19:0] dabble_step(input logic [19:0] v);
        logic [19:0] t;
        t = v;
        for (int i = 0; i < 3; i++) begin
            if (t[8+4*i +: 4] >= 4'd5) begin
                t[8+4*i +: 4] = t[8+4*i +: 4] + 4'd3;
            end
        end
        return {t[18:0], 1'b0};
    endfunction

    // ------------------------------------------------------------------
    // Conversion FSM
    // ------------------------------------------------------------------

    state_e      state_q, state_d;
    logic [19:0] shift_q, shift_d;
    logic [2:0]  iter_q, iter_d;
    logic        neg_q, neg_d;
    logic [11:0] disp_bcd_q, disp_bcd_d;
    logic        disp_neg_q, disp_neg_d;
    logic        conv_done_q, conv_done_d;

    logic        cap_neg;
    logic [7:0]  cap_mag;

    // 0x80 in signed mode negates to 0x80 again, read as magnitude 128.
    assign cap_neg = signed_mode & result_in[7];
    assign cap_mag = cap_neg ? (~result_in + 8'd1) : result_in;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        iter_d      = iter_q;
        neg_d       = neg_q;
        disp_bcd_d  = disp_bcd_q;
        disp_neg_d  = disp_neg_q;
        conv_done_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (result_valid && ena) begin
                    neg_d   = cap_neg;
                    shift_d = {12'd0, cap_mag};
                    iter_d  = 3'd0;
                    state_d = StConv;
                end
            end
            StConv: begin
                shift_d = dabble_step(shift_q);
                iter_d  = iter_q + 3'd1;
                if (iter_q == 3'd7) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                disp_bcd_d  = shift_q[19:8];
                disp_neg_d  = neg_q;
                conv_done_d = 1'b1;
                state_d     = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            shift_q     <= 20'd0;
            iter_q      <= 3'd0;
            neg_q       <= 1'b0;
            disp_bcd_q  <= 12'd0;
            disp_neg_q  <= 1'b0;
            conv_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            iter_q      <= iter_d;
            neg_q       <= neg_d;
            disp_bcd_q  <= disp_bcd_d;
            disp_neg_q  <= disp_neg_d;
            conv_done_q <= conv_done_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign conv_done = conv_done_q;

    // ------------------------------------------------------------------
    // Display scan
    // ------------------------------------------------------------------

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [6:0]      seg_q, seg_d;
    logic [3:0]      digit_en_q, digit_en_d;
    logic            dp_q;

    logic [3:0]      hund, tens, ones;
    logic [6:0]      pos_code;

    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (ena) begin
            if (cnt_q == CntMax) begin
                cnt_d = '0;
                idx_d = idx_q + 2'd1;
            end else begin
                cnt_d = cnt_q + CntOne;
            end
        end
    end

    // Output registers are fed from next-state values. This keeps digit_en
    // aligned with the index and makes new digits appear with conv_done.
    assign hund = disp_bcd_d[11:8];
    assign tens = disp_bcd_d[7:4];
    assign ones = disp_bcd_d[3:0];

    always_comb begin
        pos_code = SegBlank;
        unique case (idx_d)
            2'd0: pos_code = seg7(ones);
            2'd1: pos_code = ((hund != 4'd0) || (tens != 4'd0)) ? seg7(tens) : SegBlank;
            2'd2: pos_code = (hund != 4'd0) ? seg7(hund) : SegBlank;
            2'd3: pos_code = disp_neg_d ? SegMinus : SegBlank;
        endcase
    end

    always_comb begin
        seg_d      = SegInv;
        digit_en_d = EnInv;
        if (ena) begin
            seg_d      = pos_code ^ SegInv;
            digit_en_d = (4'b0001 << idx_d) ^ EnInv;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            idx_q      <= 2'd0;
            seg_q      <= SegInv;
            digit_en_q <= EnInv;
            dp_q       <= SEG_ACTIVE_LOW;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            seg_q      <= seg_d;
            digit_en_q <= digit_en_d;
            dp_q       <= SEG_ACTIVE_LOW;
        end
    end

    assign seg      = seg_q;
    assign dp       = dp_q;
    assign digit_en = digit_en_q;

endmodule

// File: tb/tb_nanocalc_result_display.sv
// Bench for nanocalc_result_display. Two instances share the stimulus. One is
// active-high with a refresh divide of 4. The other is active-low with a
// divide of 5. A behavioural model predicts every output on every cycle.
// Directed literal checks pin the model against hand-computed digit codes.

module tb_nanocalc_result_display;

    localparam int unsigned DivA = 4;
    localparam int unsigned DivB = 5;

    localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] result_in;
    logic       result_valid;
    logic       signed_mode;

    logic       busy_a, done_a, dp_a;
    logic [6:0] seg_a;
    logic [3:0] en_a;
    logic       busy_b, done_b, dp_b;
    logic [6:0] seg_b;
    logic [3:0] en_b;

    int n_cmp  = 0;
    int n_fail = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    nanocalc_result_display #(
        .REFRESH_DIV    (DivA),
        .SEG_ACTIVE_LOW (1'b0)
    ) u_dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .result_in    (result_in),
        .result_valid (result_valid),
        .signed_mode  (signed_mode),
        .busy         (busy_a),
        .conv_done    (done_a),
        .seg          (seg_a),
        .dp           (dp_a),
        .digit_en     (en_a)
    );

    nanocalc_result_display #(
        .REFRESH_DIV    (DivB),
        .SEG_ACTIVE_LOW (1'b1)
    ) u_dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .result_in    (result_in),
        .result_valid (result_valid),
        .signed_mode  (signed_mode),
        .busy         (busy_b),
        .conv_done    (done_b),
        .seg          (seg_b),
        .dp           (dp_b),
        .digit_en     (en_b)
    );

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: a conversion is a 9-cycle countdown that loads the
    // arithmetic magnitude; the scan position is derived from the number of
    // enabled clock edges since reset.
    // ------------------------------------------------------------------
    int m_left   = 0;
    int m_mag    = 0;
    bit m_neg    = 1'b0;
    int p_mag    = 0;
    bit p_neg    = 1'b0;
    bit m_done   = 1'b0;
    bit m_lit    = 1'b0;
    int m_edges  = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left  <= 0;
            m_mag   <= 0;
            m_neg   <= 1'b0;
            m_done  <= 1'b0;
            m_lit   <= 1'b0;
            m_edges <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_left != 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_mag  <= p_mag;
                    m_neg  <= p_neg;
                    m_done <= 1'b1;
                end
            end else if (result_valid && ena) begin
                m_left <= 9;
                p_neg  <= signed_mode && result_in[7];
                p_mag  <= (signed_mode && result_in[7]) ? 256 - int'(result_in)
                                                        : int'(result_in);
            end
            m_lit <= ena;
            if (ena) m_edges <= m_edges + 1;
        end
    end

    function automatic int m_idx(input int div);
        return (m_edges / div) % 4;
    endfunction

    function automatic int m_code(input int pos);
        int h, t, o;
        h = m_mag / 100;
        t = (m_mag / 10) % 10;
        o = m_mag % 10;
        case (pos)
            0:       return int'(SEG_TAB[o]);
            1:       return (h != 0 || t != 0) ? int'(SEG_TAB[t]) : 0;
            2:       return (h != 0) ? int'(SEG_TAB[h]) : 0;
            default: return m_neg ? 'h40 : 0;
        endcase
    endfunction

    function automatic int exp_en(input int div);
        return m_lit ? (1 << m_idx(div)) : 0;
    endfunction

    function automatic int exp_seg(input int div);
        return m_lit ? m_code(m_idx(div)) : 0;
    endfunction

    always @(negedge clk) begin
        if (started) begin
            check("busy_a", busy_a, int'(m_left != 0));
            check("done_a", done_a, int'(m_done));
            check("en_a", en_a, exp_en(DivA));
            check("seg_a", seg_a, exp_seg(DivA));
            check("dp_a", dp_a, 0);
            check("busy_b", busy_b, int'(m_left != 0));
            check("done_b", done_b, int'(m_done));
            check("en_b", en_b, exp_en(DivB) ^ 'hF);
            check("seg_b", seg_b, exp_seg(DivB) ^ 'h7F);
            check("dp_b", dp_b, 1);
        end
    end

    // ------------------------------------------------------------------
    // Directed helpers
    // ------------------------------------------------------------------
    int ps[4];

    // Record the segment code shown at each position of instance A over a
    // full scan rotation.
    task automatic collect();
        for (int i = 0; i < 4; i++) ps[i] = -1;
        for (int i = 0; i < 4 * DivA + 4; i++) begin
            @(negedge clk);
            case (en_a)
                4'b0001: ps[0] = int'(seg_a);
                4'b0010: ps[1] = int'(seg_a);
                4'b0100: ps[2] = int'(seg_a);
                4'b1000: ps[3] = int'(seg_a);
                default: ;
            endcase
        end
    endtask

    task automatic check_disp(input string name, input int s3, input int s2,
                              input int s1, input int s0);
        collect();
        check({name, "_ones"}, ps[0], s0);
        check({name, "_tens"}, ps[1], s1);
        check({name, "_hund"}, ps[2], s2);
        check({name, "_sign"}, ps[3], s3);
    endtask

    task automatic run_conv(input logic [7:0] v, input logic sm,
                            output int busy_cycles, output int pulses);
        @(negedge clk);
        result_in    = v;
        signed_mode  = sm;
        result_valid = 1'b1;
        @(negedge clk);
        result_valid = 1'b0;
        busy_cycles  = 0;
        pulses       = 0;
        for (int i = 0; i < 14; i++) begin
            if (busy_a) busy_cycles++;
            if (done_a) pulses++;
            @(negedge clk);
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    logic [7:0] tab_val [10] = '{8'h00, 8'h7F, 8'h80, 8'h81, 8'h63,
                                 8'h64, 8'h09, 8'h0A, 8'hFF, 8'h01};
    bit         tab_sm  [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                                 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        int bc, pc, hold_idx;
        bit found;
        logic [3:0] prev_en;

        rst_n        = 1'b1;
        ena          = 1'b0;
        result_in    = 8'h00;
        result_valid = 1'b0;
        signed_mode  = 1'b0;
        #1 rst_n = 1'b0;
        started = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_en_a", en_a, 'h0);
        check("rst_en_b", en_b, 'hF);
        check("rst_seg_b", seg_b, 'h7F);
        rst_n = 1'b1;
        ena   = 1'b1;

        // Idle display after reset shows "0".
        check("idle_busy", busy_a, 0);
        check_disp("zero", 'h00, 'h00, 'h00, 'h3F);

        // 255 unsigned: 9 busy cycles, one pulse.
        run_conv(8'hFF, 1'b0, bc, pc);
        check("ff_busy_cycles", bc, 9);
        check("ff_pulses", pc, 1);
        check_disp("d255", 'h00, 'h5B, 'h6D, 'h6D);

        run_conv(8'hF9, 1'b1, bc, pc);
        check_disp("dm7", 'h40, 'h00, 'h00, 'h07);
        run_conv(8'h80, 1'b1, bc, pc);
        check_disp("dm128", 'h40, 'h06, 'h5B, 'h7F);

        // Second strobe while busy is dropped.
        @(negedge clk);
        result_in = 8'h2A; signed_mode = 1'b0; result_valid = 1'b1;
        @(negedge clk);
        result_valid = 1'b0;
        repeat (2) @(negedge clk);
        result_in = 8'h05; result_valid = 1'b1;
        @(negedge clk);
        result_valid = 1'b0;
        pc = 0;
        for (int i = 0; i < 14; i++) begin
            if (done_a) pc++;
            @(negedge clk);
        end
        check("drop_pulses", pc, 1);
        check_disp("d42", 'h00, 'h00, 'h66, 'h5B);

        // Reset in the middle of converting 99.
        @(negedge clk);
        result_in = 8'h63; result_valid = 1'b1;
        @(negedge clk);
        result_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", busy_a, 0);
        check("midrst_en_a", en_a, 'h0);
        check("midrst_seg_a", seg_a, 'h00);
        check("midrst_en_b", en_b, 'hF);
        @(negedge clk);
        rst_n = 1'b1;
        pc = 0;
        for (int i = 0; i < 14; i++) begin
            if (done_a) pc++;
            @(negedge clk);
        end
        check("midrst_pulses", pc, 0);
        check_disp("zero2", 'h00, 'h00, 'h00, 'h3F);

        // Freeze with ena low right after a scan step.
        found   = 1'b0;
        prev_en = en_a;
        for (int i = 0; i < 4 * DivA + 2 && !found; i++) begin
            @(negedge clk);
            if (en_a != prev_en) found = 1'b1;
            prev_en = en_a;
        end
        check("scan_step_seen", int'(found), 1);
        hold_idx = m_idx(DivA);
        ena = 1'b0;
        repeat (10) @(negedge clk);
        check("off_en_a", en_a, 'h0);
        check("off_seg_a", seg_a, 'h00);
        check("off_en_b", en_b, 'hF);
        check("off_seg_b", seg_b, 'h7F);
        ena = 1'b1;
        @(negedge clk);
        check("hold_idx", en_a, 1 << hold_idx);

        // Boundary values; the per-cycle model covers them.
        for (int i = 0; i < 10; i++) begin
            run_conv(tab_val[i], tab_sm[i], bc, pc);
            check("tab_pulses", pc, 1);
        end

        // Random traffic with occasional enable drops and resets.
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            ena          = ($urandom_range(0, 15) != 0);
            result_valid = ($urandom_range(0, 5) == 0);
            result_in    = 8'($urandom);
            signed_mode  = 1'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_n = 1'b0;
                #4 rst_n = 1'b1;
            end
        end
        result_valid = 1'b0;
        repeat (12) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
